input_port_credit_arbiter: RTL and testbench
============================================

# input_port_credit_arbiter

Round-robin scheduler that shares the leaf's single upstream injection path among the `NUM_IN_PORTS` input ports of an input-port cluster. Each input port periodically emits a freespace (credit) packet: a one-cycle `freespace_update` strobe with its packet on its slice of `packet_from_input_ports`. This block buffers one packet per port and serializes the packets onto one valid/ack packet stream toward the leaf interface. It sits between the input-port cluster and the leaf-interface output mux, entirely in the `clk` (BFT) domain.

## Interface
Parameters:
- `PACKET_BITS`, 97, width of one packet.
- `NUM_IN_PORTS`, 7, number of input ports arbitrated (≥1).
- `NUM_PORT_BITS`, 4, width of the granted-port ID.
- `CNT_BITS`, 32, width of the sent-packet counter.

Ports:
- `clk`  in  1  BFT clock. Single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `freespace_update`  in  `NUM_IN_PORTS`  one-cycle strobe per port: the packet slice for that port is valid this cycle.
- `packet_from_input_ports`  in  `PACKET_BITS*NUM_IN_PORTS`  port i occupies bits `[PACKET_BITS*(i+1)-1 : PACKET_BITS*i]`.
- `packet_out`  out  `PACKET_BITS`  packet currently offered downstream.
- `packet_out_vld`  out  1  `packet_out` is valid.
- `packet_out_ack`  in  1  downstream accepts; a transfer occurs when `vld && ack` at a rising edge.
- `grant_port`  out  `NUM_PORT_BITS`  port number of the packet on `packet_out`, equal to index+2.
- `pending`  out  `NUM_IN_PORTS`  per-port holding slot occupied.
- `overflow_err`  out  `NUM_IN_PORTS`  sticky: a strobe arrived while the slot was full and not draining.
- `sent_cnt`  out  `CNT_BITS`  count of completed transfers, wraps modulo 2^`CNT_BITS`.

## Operation
- One holding slot per port: `slot_data[i]` and `pending[i]`.
- Capture rule: when `freespace_update[i]` is high:
  - If the slot is empty, or is being loaded into the output register this cycle, latch the packet and set `pending[i]=1`.
  - Otherwise keep the old packet, drop the new one, and set `overflow_err[i]=1`. It is cleared only by reset.
- Round-robin pointer `rr_last` holds the last granted index.
- Search order is `rr_last+1, rr_last+2, …`, wrapping from `NUM_IN_PORTS-1` to 0. The first pending index wins.
- FSM with two states:
  - IDLE: `packet_out_vld=0`. If any slot is pending, load the winner's packet into `packet_out`, set `grant_port=winner+2`, clear that slot's `pending` (unless it is recaptured the same cycle), set `rr_last=winner`, and go to SEND.
  - SEND: `packet_out_vld=1`, and `packet_out`/`grant_port` are held stable until ack.
    - On `vld && ack`, increment `sent_cnt`.
    - If any slot is pending, including one captured in an earlier cycle, load the next winner the same edge and stay in SEND (back-to-back, no bubble).
    - Otherwise go to IDLE.
- `packet_out_ack` while in IDLE is ignored.
- Fairness: with all ports continuously pending, each port is granted exactly once every `NUM_IN_PORTS` transfers.

## Timing
- Reset values: `packet_out=0`, `packet_out_vld=0`, `grant_port=0`, `pending=0`, `overflow_err=0`, `sent_cnt=0`, `rr_last=NUM_IN_PORTS-1` (so port 0 has first priority), state IDLE.
- Reset asserted mid-transfer drops `vld` immediately (asynchronously) and discards all buffered packets.
- Latency when idle: strobe in cycle 0 → `pending[i]=1` in cycle 1 → `packet_out_vld=1` with that packet in cycle 2.
- Throughput: one packet per cycle while `ack` is held high and slots are pending.
- All outputs are registered. There is no combinational path from `packet_out_ack` or `freespace_update` to any output.
- Boundary cases:
  - Strobe on port i in the same cycle its slot is selected: the new packet is captured, `pending[i]` stays 1, and there is no overflow.
  - Strobe on port i while its slot is full and another port is selected: overflow.
  - `sent_cnt` wraps from all-ones to 0.

## Test plan
- **Single packet:** reset; in cycle 0 strobe port 3 with packet `0x1_2345`; `ack=1` → `vld` rises in cycle 2 with `packet_out=0x1_2345` and `grant_port=5`; `sent_cnt=1` after the transfer; `vld=0` in cycle 3.
- **Fairness:** strobe all 7 ports in one cycle (packet = index), `ack=1` → output order 0,1,2,3,4,5,6 back-to-back over 7 consecutive cycles, `grant_port` 2..8.
- **Backpressure:** hold `ack=0` for 10 cycles with 2 pending → `packet_out` and `grant_port` stable, `vld=1`; on release, exactly 2 transfers occur.
- **Overflow:** port 1 slot full, `ack=0`, second strobe on port 1 → `overflow_err[1]=1` and the first packet is delivered unchanged. Separately, a strobe on the same cycle the slot is selected → no error, and both packets are delivered.
- **Rotation after grant:** after port 4 is granted, pend ports 2 and 5 → 5 is granted before 2.
- **Async reset:** assert `reset` mid-SEND between clock edges → `vld`, `pending` and `sent_cnt` go to 0 immediately. After release, a fresh strobe on port 0 is delivered with 2-cycle latency.

Source files
------------

// File: rtl/input_port_credit_arbiter.sv
// Round-robin serializer of per-input-port freespace packets onto one valid/ack stream.
// Latency: strobe -> pending next cycle -> packet_out_vld the cycle after; no-bubble when acked.
// Backpressure: packet_out held until ack; a strobe into a full, non-draining slot is dropped.
module input_port_credit_arbiter #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_PORT_BITS = 4,
    parameter int CNT_BITS      = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_IN_PORTS-1:0]              freespace_update,
    input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]  packet_from_input_ports,
    output logic [PACKET_BITS-1:0]               packet_out,
    output logic                                 packet_out_vld,
    input  logic                                 packet_out_ack,
    output logic [NUM_PORT_BITS-1:0]             grant_port,
    output logic [NUM_IN_PORTS-1:0]              pending,
    output logic [NUM_IN_PORTS-1:0]              overflow_err,
    output logic [CNT_BITS-1:0]                  sent_cnt
);

    localparam int RR_W = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q, state_d;
    logic [PACKET_BITS-1:0]    slot_q [NUM_IN_PORTS];
    logic [PACKET_BITS-1:0]    slot_d [NUM_IN_PORTS];
    logic [NUM_IN_PORTS-1:0]   pending_q, pending_d;
    logic [NUM_IN_PORTS-1:0]   ovf_q, ovf_d;
    logic [RR_W-1:0]           rr_last_q, rr_last_d;
    logic [PACKET_BITS-1:0]    pkt_q, pkt_d;
    logic [NUM_PORT_BITS-1:0]  grant_q, grant_d;
    logic [CNT_BITS-1:0]       cnt_q, cnt_d;

    logic                      win_vld;
    logic [RR_W-1:0]           win_idx;
    logic                      xfer;
    logic                      load;
    int                        idx;

    // First pending slot after the last grant, wrapping; only already-latched slots compete.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_IN_PORTS; k++) begin
            idx = (int'(rr_last_q) + k) % NUM_IN_PORTS;
            if (!win_vld && pending_q[idx]) begin
                win_vld = 1'b1;
                win_idx = RR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        rr_last_d = rr_last_q;
        pkt_d     = pkt_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;

        xfer = (state_q == SEND) && packet_out_ack;
        load = win_vld && ((state_q == IDLE) || xfer);

        if (xfer) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end

        if (load) begin
            pkt_d              = slot_q[win_idx];
            grant_d            = NUM_PORT_BITS'(win_idx) + NUM_PORT_BITS'(2);
            pending_d[win_idx] = 1'b0;
            rr_last_d          = win_idx;
            state_d            = SEND;
        end else if (xfer) begin
            state_d = IDLE;
        end

        // A slot emptied by this cycle's load may be refilled on the same edge.
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            if (freespace_update[i]) begin
                if (!pending_q[i] || (load && (win_idx == RR_W'(i)))) begin
                    slot_d[i]    = packet_from_input_ports[PACKET_BITS*i +: PACKET_BITS];
                    pending_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                slot_q[i] <= '0;
            end
            pending_q <= '0;
            ovf_q     <= '0;
            rr_last_q <= RR_W'(NUM_IN_PORTS - 1);
            pkt_q     <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            rr_last_q <= rr_last_d;
            pkt_q     <= pkt_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
        end
    end

    assign packet_out     = pkt_q;
    assign packet_out_vld = (state_q == SEND);
    assign grant_port     = grant_q;
    assign pending        = pending_q;
    assign overflow_err   = ovf_q;
    assign sent_cnt       = cnt_q;

endmodule

// File: tb/tb_input_port_credit_arbiter.sv
// Directed bench: expected transfers are queued at stimulus time and popped by a monitor on every vld&&ack.
// Counter is narrowed to 4 bits so its wrap can be reached in a short run.
module tb_input_port_credit_arbiter;

    localparam int PB = 97;
    localparam int NP = 7;
    localparam int GB = 4;
    localparam int CB = 4;

    typedef struct packed {
        logic [PB-1:0] pkt;
        logic [GB-1:0] gp;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NP-1:0]        fu = '0;
    logic [PB*NP-1:0]     pin = '0;
    logic [PB-1:0]        packet_out;
    logic                 vld;
    logic                 ack = 1'b0;
    logic [GB-1:0]        grant_port;
    logic [NP-1:0]        pending;
    logic [NP-1:0]        overflow_err;
    logic [CB-1:0]        sent_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    input_port_credit_arbiter #(
        .PACKET_BITS(PB), .NUM_IN_PORTS(NP), .NUM_PORT_BITS(GB), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset),
        .freespace_update(fu), .packet_from_input_ports(pin),
        .packet_out(packet_out), .packet_out_vld(vld), .packet_out_ack(ack),
        .grant_port(grant_port), .pending(pending),
        .overflow_err(overflow_err), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && vld && ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", {grant_port, packet_out}, '1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_packet", 128'(packet_out), 128'(e.pkt));
                check("mon_grant", 128'(grant_port), 128'(e.gp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fu    = '0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_pkt(input int port, input logic [PB-1:0] p);
        pin[PB*port +: PB] = p;
    endtask

    task automatic expect_xfer(input logic [PB-1:0] p, input int port);
        exp_t e;
        e.pkt = p;
        e.gp  = GB'(port + 2);
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [NP-1:0] mask);
        fu = mask;
        tick();
        fu = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_vld", 128'(vld), 0);
        check("rst_packet", 128'(packet_out), 0);
        check("rst_grant", 128'(grant_port), 0);
        check("rst_pending", 128'(pending), 0);
        check("rst_overflow", 128'(overflow_err), 0);
        check("rst_sent", 128'(sent_cnt), 0);

        // Single packet, 2-cycle latency
        ack = 1'b1;
        set_pkt(3, 97'h1_2345);
        expect_xfer(97'h1_2345, 3);
        pulse(7'b0001000);
        check("single_pend_c1", 128'(pending), 128'(7'b0001000));
        check("single_vld_c1", 128'(vld), 0);
        tick();
        check("single_vld_c2", 128'(vld), 1);
        check("single_pkt_c2", 128'(packet_out), 128'h1_2345);
        check("single_grant_c2", 128'(grant_port), 5);
        tick();
        check("single_vld_c3", 128'(vld), 0);
        check("single_sent", 128'(sent_cnt), 1);

        // Fairness: all ports at once, back-to-back 0..6
        do_reset();
        ack = 1'b1;
        for (int i = 0; i < NP; i++) begin
            set_pkt(i, PB'(i));
            expect_xfer(PB'(i), i);
        end
        pulse('1);
        tick();
        for (int i = 0; i < NP; i++) begin
            check("fair_vld_run", 128'(vld), 1);
            tick();
        end
        check("fair_vld_end", 128'(vld), 0);
        check("fair_sent", 128'(sent_cnt), 7);

        // Backpressure: two pending, ack low for 10 cycles
        do_reset();
        set_pkt(2, 97'hA2);
        set_pkt(5, 97'hA5);
        expect_xfer(97'hA2, 2);
        expect_xfer(97'hA5, 5);
        pulse(7'b0100100);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_vld", 128'(vld), 1);
            check("bp_pkt", 128'(packet_out), 128'hA2);
            check("bp_grant", 128'(grant_port), 4);
            tick();
        end
        check("bp_sent_held", 128'(sent_cnt), 0);
        ack = 1'b1;
        tick();
        tick();
        check("bp_sent", 128'(sent_cnt), 2);
        check("bp_vld_end", 128'(vld), 0);

        // Overflow: slot refilled while output stalled, then a third strobe
        do_reset();
        set_pkt(1, 97'h111);
        expect_xfer(97'h111, 1);
        pulse(7'b0000010);
        tick();
        set_pkt(1, 97'h222);
        expect_xfer(97'h222, 1);
        pulse(7'b0000010);
        set_pkt(1, 97'h333);
        pulse(7'b0000010);
        check("ovf_err", 128'(overflow_err), 128'(7'b0000010));
        check("ovf_pending", 128'(pending), 128'(7'b0000010));
        check("ovf_pkt_held", 128'(packet_out), 128'h111);
        ack = 1'b1;
        tick();
        tick();
        check("ovf_sent", 128'(sent_cnt), 2);
        check("ovf_sticky", 128'(overflow_err), 128'(7'b0000010));

        // Strobe in the cycle the slot is selected: recapture, no error
        do_reset();
        set_pkt(1, 97'h444);
        expect_xfer(97'h444, 1);
        pulse(7'b0000010);
        set_pkt(1, 97'h555);
        expect_xfer(97'h555, 1);
        pulse(7'b0000010);
        check("same_pending", 128'(pending), 128'(7'b0000010));
        check("same_no_ovf", 128'(overflow_err), 0);
        check("same_pkt", 128'(packet_out), 128'h444);
        ack = 1'b1;
        tick();
        tick();
        check("same_sent", 128'(sent_cnt), 2);

        // Rotation: after port 4, port 5 beats port 2
        do_reset();
        ack = 1'b1;
        set_pkt(4, 97'h44);
        expect_xfer(97'h44, 4);
        pulse(7'b0010000);
        tick();
        tick();
        set_pkt(2, 97'h22);
        set_pkt(5, 97'h55);
        expect_xfer(97'h55, 5);
        expect_xfer(97'h22, 2);
        pulse(7'b0100100);
        tick();
        check("rot_first_grant", 128'(grant_port), 7);
        tick();
        check("rot_second_grant", 128'(grant_port), 4);
        tick();
        check("rot_sent", 128'(sent_cnt), 3);

        // Async reset mid-SEND
        do_reset();
        ack = 1'b1;
        set_pkt(0, 97'hA0);
        set_pkt(1, 97'hA1);
        set_pkt(2, 97'hA2);
        expect_xfer(97'hA0, 0);
        pulse(7'b0000111);
        tick();
        tick();
        ack = 1'b0;
        check("ar_pre_vld", 128'(vld), 1);
        check("ar_pre_sent", 128'(sent_cnt), 1);
        check("ar_pre_pending", 128'(pending), 128'(7'b0000100));
        #2 reset = 1'b1;
        #1;
        check("ar_vld", 128'(vld), 0);
        check("ar_pending", 128'(pending), 0);
        check("ar_sent", 128'(sent_cnt), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        ack = 1'b1;
        set_pkt(0, 97'h77);
        expect_xfer(97'h77, 0);
        pulse(7'b0000001);
        check("ar_post_vld_c1", 128'(vld), 0);
        tick();
        check("ar_post_vld_c2", 128'(vld), 1);
        check("ar_post_pkt", 128'(packet_out), 128'h77);
        tick();

        // Counter wrap (4-bit): 14 + 1 + 1 transfers
        do_reset();
        ack = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NP; i++) begin
                set_pkt(i, PB'(16 * r + i));
                expect_xfer(PB'(16 * r + i), i);
            end
            pulse('1);
            repeat (9) tick();
        end
        check("wrap_sent_14", 128'(sent_cnt), 14);
        set_pkt(0, 97'hB0);
        expect_xfer(97'hB0, 0);
        pulse(7'b0000001);
        repeat (3) tick();
        check("wrap_sent_15", 128'(sent_cnt), 15);
        set_pkt(1, 97'hB1);
        expect_xfer(97'hB1, 1);
        pulse(7'b0000010);
        repeat (3) tick();
        check("wrap_sent_0", 128'(sent_cnt), 0);

        check("scoreboard_drained", 128'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
